// File: rtl/xs3_serial_rx.sv
// -----------------------------------------------------------------------------
// xs3_serial_rx
// Deframes excess-3 digits from a one-wire serial link. It presents each good
// digit on a 4-bit parallel port with a valid/ready handshake. Malformed,
// bad-parity and out-of-range frames are dropped and flagged with
// single-cycle pulses.
//
// Frame : start(0), d0..d3 (LSB first), [odd parity], stop(1)
//
// Handshake: a digit transfers on any rising edge where digit_valid and
// digit_ready are both 1. digit_valid then drops on that edge unless a new
// digit loads on the same edge. bcd_xs3 never changes while digit_valid is 1.
// digit_ready has no effect while digit_valid is 0.
//
// Parameters:
//   PARITY_EN   - 1: an odd-parity bit follows the data bits
//   CHECK_RANGE - 1: reject codes outside 0011..1100
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   bit_en      - one-cycle mid-bit strobe; the FSM moves only on this strobe
//   rx          - serial line, idles high
//   bcd_xs3     - received XS-3 digit (resets to 0011, XS-3 zero)
//   digit_valid - bcd_xs3 holds an undelivered digit
//   digit_ready - consumer accepts the digit
//   frame_err   - pulse: stop bit sampled low
//   parity_err  - pulse: parity mismatch
//   code_err    - pulse: code outside the decimal range
//   overrun     - pulse: good digit dropped because the output was full
// -----------------------------------------------------------------------------
module xs3_serial_rx #(
   parameter bit PARITY_EN   = 1'b1,
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_en,
   input  logic       rx,
   output logic [3:0] bcd_xs3,
   output logic       digit_valid,
   input  logic       digit_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       code_err,
   output logic       overrun
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] shreg_q, shreg_d;
   logic       pbit_q, pbit_d;
   logic [3:0] bcd_q, bcd_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;
   logic       perr_q, perr_d;
   logic       cerr_q, cerr_d;
   logic       ovr_q, ovr_d;

   logic       out_free;
   logic       parity_bad;
   logic       code_bad;

   // The output register can accept a digit if it is empty, or if it is
   // being drained on this same edge.
   assign out_free   = !valid_q || digit_ready;
   // Odd parity: data ones plus the parity bit must give an odd count.
   assign parity_bad = PARITY_EN && !(^{shreg_q, pbit_q});
   assign code_bad   = CHECK_RANGE && ((shreg_q < 4'd3) || (shreg_q > 4'd12));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      pbit_d  = pbit_q;
      bcd_d   = bcd_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      cerr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (valid_q && digit_ready) begin
         valid_d = 1'b0;
      end

      if (bit_en) begin
         case (state_q)
            S_IDLE: begin
               if (!rx) begin
                  state_d = S_DATA;
                  cnt_d   = 2'd0;
               end
            end
            S_DATA: begin
               shreg_d[cnt_q] = rx;
               cnt_d          = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = PARITY_EN ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               pbit_d  = rx;
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               // Exactly one outcome per frame, in priority order.
               if (!rx) begin
                  ferr_d = 1'b1;
               end else if (parity_bad) begin
                  perr_d = 1'b1;
               end else if (code_bad) begin
                  cerr_d = 1'b1;
               end else if (out_free) begin
                  bcd_d   = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         shreg_q <= 4'd0;
         pbit_q  <= 1'b0;
         bcd_q   <= 4'b0011;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         cerr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         pbit_q  <= pbit_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         cerr_q  <= cerr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bcd_xs3     = bcd_q;
   assign digit_valid = valid_q;
   assign frame_err   = ferr_q;
   assign parity_err  = perr_q;
   assign code_err    = cerr_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_xs3_serial_rx.sv
module tb_xs3_serial_rx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (parity + range check) ----------------
  logic       bit_en = 1'b0;
  logic       rx = 1'b1;
  logic       digit_ready = 1'b0;
  logic [3:0] bcd_xs3;
  logic       digit_valid, frame_err, parity_err, code_err, overrun;

  xs3_serial_rx #(.PARITY_EN(1'b1), .CHECK_RANGE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .bcd_xs3(bcd_xs3), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .frame_err(frame_err), .parity_err(parity_err), .code_err(code_err),
    .overrun(overrun)
  );

  // ---------------- DUT (no parity, no range check) ----------------
  logic       bit_en_np = 1'b0;
  logic       rx_np = 1'b1;
  logic       ready_np = 1'b1;
  logic [3:0] bcd_np;
  logic       valid_np, ferr_np, perr_np, cerr_np, ovr_np;

  xs3_serial_rx #(.PARITY_EN(1'b0), .CHECK_RANGE(1'b0)) u_np (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en_np), .rx(rx_np),
    .bcd_xs3(bcd_np), .digit_valid(valid_np), .digit_ready(ready_np),
    .frame_err(ferr_np), .parity_err(perr_np), .code_err(cerr_np),
    .overrun(ovr_np)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];

  // Every delivered digit (valid & ready before an edge) must match the
  // next expected digit, in order.
  always @(negedge clk) begin
    if (rst_n && digit_valid && digit_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_extra_digit: got %0d expected none", bcd_xs3);
      end else begin
        chk("mon_digit", bcd_xs3, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One bit period: a random-valued idle cycle (glitch between strobes),
  // then a single bit_en cycle carrying bit b. Returns at posedge+1 after
  // the sampling edge.
  task automatic strobe(input logic b, input logic np, input logic rdy);
    @(posedge clk); #1;
    rx    = 1'($urandom_range(0, 1));
    rx_np = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    if (np) begin rx_np = b; bit_en_np = 1'b1; end
    else    begin rx    = b; bit_en    = 1'b1; end
    if (rdy) digit_ready = 1'b1;
    @(posedge clk); #1;
    bit_en    = 1'b0;
    bit_en_np = 1'b0;
    rx        = 1'($urandom_range(0, 1));
    rx_np     = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [3:0] data, input logic par,
                            input logic stop, input logic np,
                            input logic rdy_at_stop);
    strobe(1'b0, np, 1'b0);
    for (int i = 0; i < 4; i++) strobe(data[i], np, 1'b0);
    if (!np) strobe(par, np, 1'b0);
    strobe(stop, np, rdy_at_stop);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] data;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_perr;
    logic       exp_cerr;
    logic [3:0] exp_bcd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] d, input logic p, input logic s,
                     input logic v, input logic fe, input logic pe,
                     input logic ce, input logic [3:0] b);
    vec_t r;
    r.data = d; r.par = p; r.stop = s; r.exp_valid = v;
    r.exp_ferr = fe; r.exp_perr = pe; r.exp_cerr = ce; r.exp_bcd = b;
    tbl.push_back(r);
  endtask

  initial begin
    //  data     par   stop  valid ferr  perr  cerr  bcd
    add(4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);
    add(4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011);
    add(4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
    add(4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);
    add(4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);
    add(4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111);
    add(4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000);
    add(4'b1001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001);
    add(4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010);
    add(4'b1011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
    add(4'b1100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100);
    // stop low with bad parity too: frame error wins
    add(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100);
    add(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100);
    add(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100);
    add(4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100);
    add(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100);
    add(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1100);
    add(4'b1001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001);

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd_xs3, 4'b0011);
    chk("rst_valid", digit_valid, 0);
    chk("rst_pulses", {frame_err, parity_err, code_err, overrun}, 0);
    chk("rst_np_bcd", bcd_np, 4'b0011);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- table-driven frames ----------------
    digit_ready = 1'b1;
    foreach (tbl[k]) begin
      if (tbl[k].exp_valid) exp_q.push_back(tbl[k].data);
      send_frame(tbl[k].data, tbl[k].par, tbl[k].stop, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), digit_valid, tbl[k].exp_valid);
      chk($sformatf("v%0d_bcd", k), bcd_xs3, tbl[k].exp_bcd);
      chk($sformatf("v%0d_ferr", k), frame_err, tbl[k].exp_ferr);
      chk($sformatf("v%0d_perr", k), parity_err, tbl[k].exp_perr);
      chk($sformatf("v%0d_cerr", k), code_err, tbl[k].exp_cerr);
      chk($sformatf("v%0d_ovr", k), overrun, 0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", k),
          {frame_err, parity_err, code_err, overrun}, 0);
      chk($sformatf("v%0d_valid_end", k), digit_valid, 0);
    end

    // ---------------- overrun, then accept+load on the same edge ----------
    digit_ready = 1'b0;
    exp_q.push_back(4'b0100);
    send_frame(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_first_valid", digit_valid, 1);
    chk("ovr_first_bcd", bcd_xs3, 4'b0100);
    send_frame(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_hold_bcd", bcd_xs3, 4'b0100);
    chk("ovr_hold_valid", digit_valid, 1);
    @(negedge clk);
    chk("ovr_pulse_end", overrun, 0);
    exp_q.push_back(4'b1000);
    send_frame(4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("swap_valid", digit_valid, 1);
    chk("swap_bcd", bcd_xs3, 4'b1000);
    chk("swap_no_ovr", overrun, 0);
    @(negedge clk);
    chk("swap_drained", digit_valid, 0);

    // ---------------- reset mid-frame with a held digit ----------------
    digit_ready = 1'b0;
    send_frame(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("held_valid", digit_valid, 1);
    strobe(1'b0, 1'b0, 1'b0);   // start
    strobe(1'b0, 1'b0, 1'b0);   // d0 of 1100
    strobe(1'b0, 1'b0, 1'b0);   // d1 of 1100
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_bcd", bcd_xs3, 4'b0011);
    chk("mrst_valid", digit_valid, 0);
    chk("mrst_pulses", {frame_err, parity_err, code_err, overrun}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    digit_ready = 1'b1;
    exp_q.push_back(4'b1100);
    send_frame(4'b1100, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_valid", digit_valid, 1);
    chk("post_rst_bcd", bcd_xs3, 4'b1100);
    chk("post_rst_pulses", {frame_err, parity_err, code_err, overrun}, 0);

    // ---------------- no parity, no range check (6-strobe frames) --------
    send_frame(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("np_valid", valid_np, 1);
    chk("np_bcd", bcd_np, 4'b1111);
    chk("np_pulses", {ferr_np, perr_np, cerr_np, ovr_np}, 0);
    send_frame(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("np0_valid", valid_np, 1);
    chk("np0_bcd", bcd_np, 4'b0000);
    chk("np0_pulses", {ferr_np, perr_np, cerr_np, ovr_np}, 0);

    // ---------------- report ----------------
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
